// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and helpers for the memory bus arbiter: FSM state encoding,
// bus owner codes, default watchdog limit and the round-robin pick.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef enum logic {
        GNT_FETCH = 1'b0,
        GNT_DATA  = 1'b1
    } grant_t;

    localparam int unsigned LP_TIMEOUT_DEF = 32'd16;

    // Round-robin pick: on a tie the side that did not own the bus last wins;
    // a lone requester always wins.
    function automatic grant_t f_arbitrate(input logic i_req, input logic d_req, input grant_t last);
        grant_t g;
        if (i_req && d_req) begin
            g = (last == GNT_DATA) ? GNT_FETCH : GNT_DATA;
        end else if (d_req) begin
            g = GNT_DATA;
        end else begin
            g = GNT_FETCH;
        end
        return g;
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Bundle of the fetch port, data port, memory port and status signals.
// slave  = the arbiter's view; master = requesters plus memory.
interface mem_bus_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          iI_Req;
    logic [AW-1:0] iI_Addr;
    logic          oI_Ack;
    logic          oI_Err;
    logic [DW-1:0] oI_RData;

    logic          iD_Req;
    logic          iD_Wr;
    logic [AW-1:0] iD_Addr;
    logic [DW-1:0] iD_WData;
    logic          oD_Ack;
    logic          oD_Err;
    logic [DW-1:0] oD_RData;

    logic          oMem_Req;
    logic          oMem_Wr;
    logic [AW-1:0] oMem_Addr;
    logic [DW-1:0] oMem_WData;
    logic          iMem_Rdy;
    logic [DW-1:0] iMem_RData;

    logic          oBusy;
    logic          oGrant;

    modport slave (
        input  iI_Req, iI_Addr,
        output oI_Ack, oI_Err, oI_RData,
        input  iD_Req, iD_Wr, iD_Addr, iD_WData,
        output oD_Ack, oD_Err, oD_RData,
        output oMem_Req, oMem_Wr, oMem_Addr, oMem_WData,
        input  iMem_Rdy, iMem_RData,
        output oBusy, oGrant
    );

    modport master (
        output iI_Req, iI_Addr,
        input  oI_Ack, oI_Err, oI_RData,
        output iD_Req, iD_Wr, iD_Addr, iD_WData,
        input  oD_Ack, oD_Err, oD_RData,
        input  oMem_Req, oMem_Wr, oMem_Addr, oMem_WData,
        output iMem_Rdy, iMem_RData,
        input  oBusy, oGrant
    );
endinterface

// File: rtl/mem_bus_arbiter_watchdog.sv
// Bus watchdog: counts cycles spent waiting on memory and flags the last
// allowed cycle. A TIMEOUT of 0 removes the counter entirely.
module bus_watchdog #(
    parameter int unsigned TIMEOUT = 32'd16,
    parameter int          TO_W    = 5
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expire
);
    generate
        if (TIMEOUT == 32'd0) begin : g_off
            assign o_expire = 1'b0;
        end else begin : g_on
            localparam logic [TO_W-1:0] LP_LAST = TO_W'(TIMEOUT - 32'd1);
            localparam logic [TO_W-1:0] LP_ONE  = TO_W'(32'd1);
            logic [TO_W-1:0] r_cnt;

            // Wait-cycle counter: zeroed when a transaction starts, advanced while waiting.
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    r_cnt <= {TO_W{1'b0}};
                end else if (i_clr) begin
                    r_cnt <= {TO_W{1'b0}};
                end else if (i_en) begin
                    r_cnt <= r_cnt + LP_ONE;
                end else begin
                    r_cnt <= r_cnt;
                end
            end

            assign o_expire = i_en && (r_cnt == LP_LAST);
        end
    endgenerate
endmodule

// File: rtl/mem_bus_arbiter.sv
// Memory bus arbiter: shares one memory port between instruction fetch and
// data access. IDLE picks an owner, BUSY holds the request until memory is
// ready or the watchdog expires, DONE pulses the owner's Ack for one cycle.
module mem_bus_arbiter
    import mem_arb_pkg::*;
#(
    parameter int          AW      = 32,
    parameter int          DW      = 32,
    parameter int unsigned TIMEOUT = LP_TIMEOUT_DEF,
    parameter int          TO_W    = 5
) (
    input  logic                  iClk,
    input  logic                  nRst,
    mem_bus_arbiter_if.slave      io_bus
);
    state_t        r_state;
    state_t        w_next_state;
    grant_t        r_grant;
    grant_t        w_grant_sel;
    logic          w_start;
    logic          w_finish;
    logic          w_timeout;
    logic          w_expire;

    logic          r_mem_req;
    logic          r_mem_wr;
    logic [AW-1:0] r_mem_addr;
    logic [DW-1:0] r_mem_wdata;
    logic          r_busy;
    logic          r_i_ack;
    logic          r_i_err;
    logic [DW-1:0] r_i_rdata;
    logic          r_d_ack;
    logic          r_d_err;
    logic [DW-1:0] r_d_rdata;

    bus_watchdog #(
        .TIMEOUT (TIMEOUT),
        .TO_W    (TO_W)
    ) u_watchdog (
        .i_clk    (iClk),
        .i_rst_n  (nRst),
        .i_clr    (w_start),
        .i_en     (r_state == ST_BUSY),
        .o_expire (w_expire)
    );

    // State register.
    always_ff @(posedge iClk or negedge nRst) begin
        if (!nRst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; DONE ignores requests so the Ack cycle is never extended.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (io_bus.iI_Req || io_bus.iD_Req) begin
                    w_next_state = ST_BUSY;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (io_bus.iMem_Rdy || w_expire) begin
                    w_next_state = ST_DONE;
                end else begin
                    w_next_state = ST_BUSY;
                end
            end
            ST_DONE: w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Transaction strobes feeding the output registers; ready beats the watchdog.
    always_comb begin
        w_start     = (r_state == ST_IDLE) && (io_bus.iI_Req || io_bus.iD_Req);
        w_finish    = (r_state == ST_BUSY) && (io_bus.iMem_Rdy || w_expire);
        w_timeout   = w_finish && !io_bus.iMem_Rdy;
        w_grant_sel = f_arbitrate(io_bus.iI_Req, io_bus.iD_Req, r_grant);
    end

    // Owner and request latch: frozen for the whole of BUSY, cleared when it ends.
    always_ff @(posedge iClk or negedge nRst) begin
        if (!nRst) begin
            r_grant     <= GNT_FETCH;
            r_mem_wr    <= 1'b0;
            r_mem_addr  <= {AW{1'b0}};
            r_mem_wdata <= {DW{1'b0}};
        end else if (w_start) begin
            r_grant     <= w_grant_sel;
            r_mem_wr    <= (w_grant_sel == GNT_DATA) && io_bus.iD_Wr;
            r_mem_addr  <= (w_grant_sel == GNT_DATA) ? io_bus.iD_Addr : io_bus.iI_Addr;
            r_mem_wdata <= ((w_grant_sel == GNT_DATA) && io_bus.iD_Wr) ? io_bus.iD_WData : {DW{1'b0}};
        end else if (w_finish) begin
            r_grant     <= r_grant;
            r_mem_wr    <= 1'b0;
            r_mem_addr  <= {AW{1'b0}};
            r_mem_wdata <= {DW{1'b0}};
        end else begin
            r_grant     <= r_grant;
            r_mem_wr    <= r_mem_wr;
            r_mem_addr  <= r_mem_addr;
            r_mem_wdata <= r_mem_wdata;
        end
    end

    // Status and response registers; read data holds until the owner's next completion.
    always_ff @(posedge iClk or negedge nRst) begin
        if (!nRst) begin
            r_mem_req <= 1'b0;
            r_busy    <= 1'b0;
            r_i_ack   <= 1'b0;
            r_i_err   <= 1'b0;
            r_i_rdata <= {DW{1'b0}};
            r_d_ack   <= 1'b0;
            r_d_err   <= 1'b0;
            r_d_rdata <= {DW{1'b0}};
        end else begin
            r_mem_req <= (w_next_state == ST_BUSY);
            r_busy    <= (w_next_state != ST_IDLE);
            r_i_ack   <= w_finish && (r_grant == GNT_FETCH);
            r_i_err   <= w_timeout && (r_grant == GNT_FETCH);
            r_d_ack   <= w_finish && (r_grant == GNT_DATA);
            r_d_err   <= w_timeout && (r_grant == GNT_DATA);
            if (w_finish && (r_grant == GNT_FETCH)) begin
                r_i_rdata <= w_timeout ? {DW{1'b0}} : io_bus.iMem_RData;
            end else begin
                r_i_rdata <= r_i_rdata;
            end
            if (w_finish && (r_grant == GNT_DATA)) begin
                r_d_rdata <= w_timeout ? {DW{1'b0}} : io_bus.iMem_RData;
            end else begin
                r_d_rdata <= r_d_rdata;
            end
        end
    end

    assign io_bus.oMem_Req   = r_mem_req;
    assign io_bus.oMem_Wr    = r_mem_wr;
    assign io_bus.oMem_Addr  = r_mem_addr;
    assign io_bus.oMem_WData = r_mem_wdata;
    assign io_bus.oBusy      = r_busy;
    assign io_bus.oGrant     = r_grant;
    assign io_bus.oI_Ack     = r_i_ack;
    assign io_bus.oI_Err     = r_i_err;
    assign io_bus.oI_RData   = r_i_rdata;
    assign io_bus.oD_Ack     = r_d_ack;
    assign io_bus.oD_Err     = r_d_err;
    assign io_bus.oD_RData   = r_d_rdata;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter with hand-computed expectations.
module tb_mem_bus_arbiter;
    logic iClk = 1'b0;
    logic nRst = 1'b0;
    int   n_total = 0;
    int   n_bad   = 0;

    always #5 iClk = ~iClk;

    mem_bus_arbiter_if #(.AW(32), .DW(32)) bus_if ();

    mem_bus_arbiter #(
        .AW(32), .DW(32), .TIMEOUT(32'd16), .TO_W(5)
    ) u_dut (
        .iClk   (iClk),
        .nRst   (nRst),
        .io_bus (bus_if.slave)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge iClk);
        #1;
    endtask

    task automatic idle_inputs();
        bus_if.iI_Req     = 1'b0;
        bus_if.iI_Addr    = 32'd0;
        bus_if.iD_Req     = 1'b0;
        bus_if.iD_Wr      = 1'b0;
        bus_if.iD_Addr    = 32'd0;
        bus_if.iD_WData   = 32'd0;
        bus_if.iMem_Rdy   = 1'b0;
        bus_if.iMem_RData = 32'd0;
    endtask

    // Requests must already be driven; returns in the Ack cycle.
    task automatic serve(input string tag, input int waits, input logic [31:0] rd,
                         input logic exp_wr, input logic [31:0] exp_addr, input logic [31:0] exp_wdata);
        tick();
        for (int k = 0; k <= waits; k++) begin
            if (k == waits) begin
                bus_if.iMem_Rdy   = 1'b1;
                bus_if.iMem_RData = rd;
            end
            check_val({tag, "_req"},   32'(bus_if.oMem_Req), 32'd1);
            check_val({tag, "_addr"},  bus_if.oMem_Addr, exp_addr);
            check_val({tag, "_wr"},    32'(bus_if.oMem_Wr), 32'(exp_wr));
            check_val({tag, "_wdata"}, bus_if.oMem_WData, exp_wdata);
            check_val({tag, "_noack"}, 32'(bus_if.oI_Ack | bus_if.oD_Ack), 32'd0);
            tick();
        end
        bus_if.iMem_Rdy   = 1'b0;
        bus_if.iMem_RData = 32'd0;
        check_val({tag, "_req_off"}, 32'(bus_if.oMem_Req), 32'd0);
    endtask

    task automatic check_done(input string tag, input logic exp_d, input logic exp_err, input logic [31:0] exp_rd);
        check_val({tag, "_d_ack"}, 32'(bus_if.oD_Ack), 32'(exp_d));
        check_val({tag, "_i_ack"}, 32'(bus_if.oI_Ack), 32'(!exp_d));
        check_val({tag, "_grant"}, 32'(bus_if.oGrant), 32'(exp_d));
        check_val({tag, "_err"},   32'(exp_d ? bus_if.oD_Err : bus_if.oI_Err), 32'(exp_err));
        check_val({tag, "_rdata"}, exp_d ? bus_if.oD_RData : bus_if.oI_RData, exp_rd);
    endtask

    initial begin
        idle_inputs();
        nRst = 1'b0;
        #12;
        check_val("rst_mem_req", 32'(bus_if.oMem_Req), 32'd0);
        check_val("rst_busy",    32'(bus_if.oBusy),    32'd0);
        check_val("rst_grant",   32'(bus_if.oGrant),   32'd0);
        check_val("rst_acks",    32'(bus_if.oI_Ack | bus_if.oD_Ack), 32'd0);
        check_val("rst_i_rdata", bus_if.oI_RData, 32'd0);
        check_val("rst_d_rdata", bus_if.oD_RData, 32'd0);
        check_val("rst_addr",    bus_if.oMem_Addr, 32'd0);
        @(negedge iClk);
        nRst = 1'b1;
        tick();

        // Simultaneous requests held throughout: owners alternate D, I, D, I.
        bus_if.iI_Req  = 1'b1;
        bus_if.iI_Addr = 32'h0000_0200;
        bus_if.iD_Req  = 1'b1;
        bus_if.iD_Wr   = 1'b0;
        bus_if.iD_Addr = 32'h0000_0300;
        for (int k = 0; k < 4; k++) begin
            if ((k % 2) == 0) begin
                serve("t3_d", 0, 32'hD000_0000 + 32'(k), 1'b0, 32'h0000_0300, 32'd0);
                check_done("t3_d", 1'b1, 1'b0, 32'hD000_0000 + 32'(k));
            end else begin
                serve("t3_i", 0, 32'h1000_0000 + 32'(k), 1'b0, 32'h0000_0200, 32'd0);
                check_done("t3_i", 1'b0, 1'b0, 32'h1000_0000 + 32'(k));
            end
            tick();
            check_val("t3_idle", 32'(bus_if.oBusy), 32'd0);
        end
        idle_inputs();
        tick();

        // Fetch read, zero wait states.
        bus_if.iI_Req  = 1'b1;
        bus_if.iI_Addr = 32'h0000_0100;
        serve("t1", 0, 32'h0BAD_F00D, 1'b0, 32'h0000_0100, 32'd0);
        check_done("t1", 1'b0, 1'b0, 32'h0BAD_F00D);
        bus_if.iI_Req = 1'b0;
        tick();
        check_val("t1_idle", 32'(bus_if.oBusy), 32'd0);
        check_val("t1_ack_pulse", 32'(bus_if.oI_Ack), 32'd0);

        // Store with three wait states.
        bus_if.iD_Req   = 1'b1;
        bus_if.iD_Wr    = 1'b1;
        bus_if.iD_Addr  = 32'h0000_0040;
        bus_if.iD_WData = 32'hDEAD_BEEF;
        serve("t2", 3, 32'h7777_7777, 1'b1, 32'h0000_0040, 32'hDEAD_BEEF);
        check_done("t2", 1'b1, 1'b0, 32'h7777_7777);
        idle_inputs();
        tick();

        // Memory ready while idle is ignored.
        bus_if.iMem_Rdy   = 1'b1;
        bus_if.iMem_RData = 32'h5555_5555;
        tick();
        check_val("idle_rdy_busy", 32'(bus_if.oBusy), 32'd0);
        check_val("idle_rdy_ack",  32'(bus_if.oI_Ack | bus_if.oD_Ack), 32'd0);
        check_val("idle_rdy_data", bus_if.oD_RData, 32'h7777_7777);
        idle_inputs();

        // Watchdog timeout: request held 16 cycles, then error Ack with zero data.
        bus_if.iD_Req  = 1'b1;
        bus_if.iD_Addr = 32'h0000_0080;
        tick();
        bus_if.iD_Addr = 32'h0000_FFF0;
        for (int k = 0; k < 16; k++) begin
            check_val("t4_req",  32'(bus_if.oMem_Req), 32'd1);
            check_val("t4_addr", bus_if.oMem_Addr, 32'h0000_0080);
            check_val("t4_noack", 32'(bus_if.oD_Ack), 32'd0);
            tick();
        end
        check_done("t4", 1'b1, 1'b1, 32'd0);
        check_val("t4_req_off", 32'(bus_if.oMem_Req), 32'd0);
        idle_inputs();
        tick();
        check_val("t4_idle", 32'(bus_if.oBusy), 32'd0);

        // Ready on the expiry cycle wins over the watchdog.
        bus_if.iD_Req  = 1'b1;
        bus_if.iD_Addr = 32'h0000_0084;
        tick();
        for (int k = 0; k < 16; k++) begin
            if (k == 15) begin
                bus_if.iMem_Rdy   = 1'b1;
                bus_if.iMem_RData = 32'hCAFE_F00D;
            end
            check_val("t5_req", 32'(bus_if.oMem_Req), 32'd1);
            tick();
        end
        bus_if.iMem_Rdy = 1'b0;
        check_done("t5", 1'b1, 1'b0, 32'hCAFE_F00D);
        idle_inputs();
        tick();

        // Asynchronous reset in the middle of a transaction.
        bus_if.iD_Req  = 1'b1;
        bus_if.iD_Addr = 32'h0000_0090;
        tick();
        check_val("t6_req_before", 32'(bus_if.oMem_Req), 32'd1);
        tick();
        #2;
        nRst = 1'b0;
        #1;
        check_val("t6_rst_req",   32'(bus_if.oMem_Req), 32'd0);
        check_val("t6_rst_busy",  32'(bus_if.oBusy),    32'd0);
        check_val("t6_rst_grant", 32'(bus_if.oGrant),   32'd0);
        check_val("t6_rst_data",  bus_if.oD_RData,      32'd0);
        idle_inputs();
        @(negedge iClk);
        nRst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check_val("t6_no_ack", 32'(bus_if.oI_Ack | bus_if.oD_Ack), 32'd0);
        end
        bus_if.iI_Req  = 1'b1;
        bus_if.iI_Addr = 32'h0000_0104;
        serve("t6", 1, 32'h1234_5678, 1'b0, 32'h0000_0104, 32'd0);
        check_done("t6", 1'b0, 1'b0, 32'h1234_5678);
        idle_inputs();
        tick();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
